// File: rtl/filter_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
//   Shared definitions for the 5x5 window generator and the convolution stage.
//   WIN_SIZE : window edge length (taps per row / rows per window)
//   LB_NUM   : number of line memories needed to hold the previous lines
//   state_t  : frame-tracking FSM states
// -----------------------------------------------------------------------------
package filter_pkg;

    localparam int WIN_SIZE = 5;
    localparam int LB_NUM   = WIN_SIZE - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/filter_window_5x5_if.sv
// -----------------------------------------------------------------------------
// filter_window_5x5_if
//   Bundles the pixel stream into the window generator and the 5x5 window
//   coming out of it.
//   vs, de, data : raster input (frame start, pixel valid, pixel)
//   win_de       : window valid pulse
//   taps[r][c]   : window taps, r = 0 oldest line, c = 0 leftmost column
//   master       : pixel source / window consumer side
//   slave        : window generator side
// -----------------------------------------------------------------------------
interface filter_window_5x5_if
    import filter_pkg::*;
#(
    parameter int DATA_WIDTH = 8
);

    logic                  vs;
    logic                  de;
    logic [DATA_WIDTH-1:0] data;
    logic                  win_de;
    logic [DATA_WIDTH-1:0] taps [WIN_SIZE][WIN_SIZE];

    modport master (output vs, de, data, input  win_de, taps);
    modport slave  (input  vs, de, data, output win_de, taps);

endinterface

// File: rtl/filter_line_buf.sv
// -----------------------------------------------------------------------------
// filter_line_buf
//   One line of pixel storage, DEPTH x DATA_WIDTH, single address port,
//   synchronous read.
//   clk     : clock
//   i_en    : access strobe (one per accepted pixel)
//   i_addr  : column address
//   i_wdata : write data belonging to the PREVIOUS access
//   o_rdata : mem[i_addr] as it was before this access, valid next cycle
//
//   Writes land one access behind the read: the data for a cascaded line
//   memory is the upstream memory's read data, which only exists one cycle
//   after the read. Holding the address for one access lets every line memory
//   read and write on the same beat without adding latency. The read of a
//   column always happens a full line after its deferred write, so the lag is
//   never visible.
// -----------------------------------------------------------------------------
module filter_line_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_rdata;

    // NOTE: no reset here -- a reset on a RAM array prevents block-RAM
    // inference, and stale contents are always overwritten before use.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata          <= r_mem[i_addr];
            r_mem[r_wr_addr] <= i_wdata;
            r_wr_addr        <= i_addr;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/filter_window_5x5.sv
// -----------------------------------------------------------------------------
// filter_window_5x5
//   Raster-to-window generator for the 5x5 convolution stage. Each accepted
//   pixel produces, two cycles later, the 5x5 neighbourhood whose bottom-right
//   tap is that pixel; o_de marks the fully populated windows only.
//   clk, rstn     : clock, asynchronous active-low reset
//   i_vs          : frame-start pulse (never with i_de)
//   i_de, i_data  : pixel valid and pixel, raster order
//   o_de          : window valid pulse
//   o_x00..o_x44  : window taps o_x<row><col>, row 0 oldest, col 0 leftmost
// -----------------------------------------------------------------------------
module filter_window_5x5
    import filter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_vs,
    input  logic                  i_de,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_de,
    output logic [DATA_WIDTH-1:0] o_x00, o_x01, o_x02, o_x03, o_x04,
    output logic [DATA_WIDTH-1:0] o_x10, o_x11, o_x12, o_x13, o_x14,
    output logic [DATA_WIDTH-1:0] o_x20, o_x21, o_x22, o_x23, o_x24,
    output logic [DATA_WIDTH-1:0] o_x30, o_x31, o_x32, o_x33, o_x34,
    output logic [DATA_WIDTH-1:0] o_x40, o_x41, o_x42, o_x43, o_x44
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_col_cnt, w_col_nxt;
    logic [RW-1:0]   r_row_cnt, w_row_nxt;
    logic            w_accept;
    logic            w_win_ok;

    // ---------------- frame FSM and raster counters ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_col_cnt <= w_col_nxt;
            r_row_cnt <= w_row_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col_cnt;
        w_row_nxt   = r_row_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (i_vs) begin
                    w_state_nxt = ACTIVE;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                end
            end
            ACTIVE: begin
                if (i_vs) begin
                    w_col_nxt = '0;
                    w_row_nxt = '0;
                end else if (i_de) begin
                    w_accept = 1'b1;
                    if (r_col_cnt == CW'(IMG_WIDTH - 1)) begin
                        w_col_nxt = '0;
                        if (r_row_cnt == RW'(IMG_HEIGHT - 1)) begin
                            w_row_nxt   = '0;
                            w_state_nxt = DONE;
                        end else begin
                            w_row_nxt = r_row_cnt + 1'b1;
                        end
                    end else begin
                        w_col_nxt = r_col_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Window is fully populated once four lines and four columns precede it.
    assign w_win_ok = (r_row_cnt >= RW'(WIN_SIZE - 1)) &&
                      (r_col_cnt >= CW'(WIN_SIZE - 1));

    // ---------------- S1: line memories + delayed pixel ----------------
    logic                  r_s1_valid;
    logic                  r_s1_win;
    logic [DATA_WIDTH-1:0] r_s1_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_win   <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_win   <= w_accept && w_win_ok;
            if (w_accept) begin
                r_s1_data <= i_data;
            end
        end
    end

    logic [LB_NUM-1:0][DATA_WIDTH-1:0] w_lb_wdata;
    logic [LB_NUM-1:0][DATA_WIDTH-1:0] w_lb_rdata;

    // LB0 stores the newest line; LBk takes over what LB(k-1) just read.
    // r_s1_data still holds the previous beat's pixel, matching the
    // one-access write lag inside the line memory.
    for (genvar k = 0; k < LB_NUM; k++) begin : g_lb
        if (k == 0) begin : g_head
            assign w_lb_wdata[k] = r_s1_data;
        end else begin : g_chain
            assign w_lb_wdata[k] = w_lb_rdata[k-1];
        end
        filter_line_buf #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH),
            .ADDR_WIDTH (CW)
        ) u_lb (
            .clk     (clk),
            .i_en    (w_accept),
            .i_addr  (r_col_cnt),
            .i_wdata (w_lb_wdata[k]),
            .o_rdata (w_lb_rdata[k])
        );
    end

    // Column entering the window: row 4 newest pixel, row 0 from LB3.
    logic [WIN_SIZE-1:0][DATA_WIDTH-1:0] w_col;

    always_comb begin
        w_col[WIN_SIZE-1] = r_s1_data;
        for (int k = 0; k < LB_NUM; k++) begin
            w_col[LB_NUM-1-k] = w_lb_rdata[k];
        end
    end

    // ---------------- S2: window shift register ----------------
    logic [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_WIDTH-1:0] r_win;  // [row][col]
    logic                                              r_s2_de;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_win   <= '0;
            r_s2_de <= 1'b0;
        end else begin
            r_s2_de <= r_s1_valid && r_s1_win;
            if (r_s1_valid) begin
                for (int r = 0; r < WIN_SIZE; r++) begin
                    for (int c = 0; c < WIN_SIZE - 1; c++) begin
                        r_win[r][c] <= r_win[r][c+1];
                    end
                    r_win[r][WIN_SIZE-1] <= w_col[r];
                end
            end
        end
    end

    assign o_de  = r_s2_de;
    assign o_x00 = r_win[0][0];
    assign o_x01 = r_win[0][1];
    assign o_x02 = r_win[0][2];
    assign o_x03 = r_win[0][3];
    assign o_x04 = r_win[0][4];
    assign o_x10 = r_win[1][0];
    assign o_x11 = r_win[1][1];
    assign o_x12 = r_win[1][2];
    assign o_x13 = r_win[1][3];
    assign o_x14 = r_win[1][4];
    assign o_x20 = r_win[2][0];
    assign o_x21 = r_win[2][1];
    assign o_x22 = r_win[2][2];
    assign o_x23 = r_win[2][3];
    assign o_x24 = r_win[2][4];
    assign o_x30 = r_win[3][0];
    assign o_x31 = r_win[3][1];
    assign o_x32 = r_win[3][2];
    assign o_x33 = r_win[3][3];
    assign o_x34 = r_win[3][4];
    assign o_x40 = r_win[4][0];
    assign o_x41 = r_win[4][1];
    assign o_x42 = r_win[4][2];
    assign o_x43 = r_win[4][3];
    assign o_x44 = r_win[4][4];

endmodule

// File: tb/tb_filter_window_5x5.sv
// -----------------------------------------------------------------------------
// tb_filter_window_5x5
//   Directed bench for filter_window_5x5 with an 8x6 image, pixel = row*16+col
//   (plus a per-frame offset). Expected windows come from the pixel formula;
//   a scoreboard holds each expected window with the cycle it must appear in.
// -----------------------------------------------------------------------------
module tb_filter_window_5x5;
    import filter_pkg::*;

    localparam int DW    = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;

    typedef logic [24:0][DW-1:0] win_t;   // index r*5+c
    typedef struct {
        int   cyc;
        win_t win;
    } exp_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   n_de;
    exp_t sb[$];

    // bench-side frame model
    bit         m_active;
    int         m_r;
    int         m_c;
    logic [7:0] m_base;
    bit         first_pending;
    win_t       first_win;
    win_t       last_win;

    filter_window_5x5_if #(.DATA_WIDTH(DW)) bus ();

    filter_window_5x5 #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (IMG_W),
        .IMG_HEIGHT (IMG_H)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .i_vs   (bus.vs),
        .i_de   (bus.de),
        .i_data (bus.data),
        .o_de   (bus.win_de),
        .o_x00  (bus.taps[0][0]), .o_x01 (bus.taps[0][1]), .o_x02 (bus.taps[0][2]),
        .o_x03  (bus.taps[0][3]), .o_x04 (bus.taps[0][4]),
        .o_x10  (bus.taps[1][0]), .o_x11 (bus.taps[1][1]), .o_x12 (bus.taps[1][2]),
        .o_x13  (bus.taps[1][3]), .o_x14 (bus.taps[1][4]),
        .o_x20  (bus.taps[2][0]), .o_x21 (bus.taps[2][1]), .o_x22 (bus.taps[2][2]),
        .o_x23  (bus.taps[2][3]), .o_x24 (bus.taps[2][4]),
        .o_x30  (bus.taps[3][0]), .o_x31 (bus.taps[3][1]), .o_x32 (bus.taps[3][2]),
        .o_x33  (bus.taps[3][3]), .o_x34 (bus.taps[3][4]),
        .o_x40  (bus.taps[4][0]), .o_x41 (bus.taps[4][1]), .o_x42 (bus.taps[4][2]),
        .o_x43  (bus.taps[4][3]), .o_x44 (bus.taps[4][4])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pix(input logic [7:0] base, input int r, input int c);
        return base + 8'(r * 16 + c);
    endfunction

    function automatic win_t win_of(input logic [7:0] base, input int rr, input int cc);
        win_t w;
        for (int r = 0; r < WIN_SIZE; r++)
            for (int c = 0; c < WIN_SIZE; c++)
                w[r*5+c] = pix(base, rr - 4 + r, cc - 4 + c);
        return w;
    endfunction

    function automatic win_t grab_taps();
        win_t w;
        for (int r = 0; r < WIN_SIZE; r++)
            for (int c = 0; c < WIN_SIZE; c++)
                w[r*5+c] = bus.taps[r][c];
        return w;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (bus.win_de) begin
            win_t got;
            exp_t e;
            got = grab_taps();
            n_de++;
            if (first_pending) begin
                first_win     = got;
                first_pending = 1'b0;
            end
            last_win = got;
            if (sb.size() == 0) begin
                check("spurious_de", 200'(1), 200'(0));
            end else begin
                e = sb.pop_front();
                check("latency", 200'(cyc), 200'(e.cyc));
                check("window", got, e.win);
            end
        end
    end

    // ---------------- drivers (called #1 after a rising edge) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_vs();
        bus.vs   = 1'b1;
        m_active = 1'b1;
        m_r      = 0;
        m_c      = 0;
        idle(1);
        bus.vs   = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d);
        exp_t e;
        bus.de   = 1'b1;
        bus.data = d;
        if (m_active) begin
            if (m_r >= 4 && m_c >= 4) begin
                e.cyc = cyc + 2;
                e.win = win_of(m_base, m_r, m_c);
                sb.push_back(e);
            end
            if (m_c == IMG_W - 1) begin
                m_c = 0;
                if (m_r == IMG_H - 1) m_active = 1'b0;
                else                  m_r++;
            end else begin
                m_c++;
            end
        end
        idle(1);
        bus.de = 1'b0;
    endtask

    task automatic frame(input logic [7:0] base, input int nbeats, input bit gaps, input bit with_vs);
        if (with_vs) send_vs();
        m_base = base;
        for (int i = 0; i < nbeats; i++) begin
            beat(pix(base, i / IMG_W, i % IMG_W));
            if (gaps) idle(int'($urandom_range(0, 3)));
        end
    endtask

    task automatic drain(input string tag, input int n0, input int exp_n);
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        if (sb.size() != 0) begin
            check({tag, "_drain"}, 200'(sb.size()), 200'(0));
            sb.delete();
        end
        idle(3);
        check({tag, "_count"}, 200'(n_de - n0), 200'(exp_n));
    endtask

    task automatic start(output int n0);
        n0            = n_de;
        first_pending = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        int n0;
        n_cmp = 0; n_err = 0; n_de = 0;
        m_active = 1'b0; m_r = 0; m_c = 0; m_base = 8'h00;
        first_pending = 1'b0;
        first_win = '0; last_win = '0;
        rstn = 1'b0; bus.vs = 1'b0; bus.de = 1'b0; bus.data = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_de", 200'(bus.win_de), 200'(0));
        check("rst_taps", grab_taps(), '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(2);

        // beats without a frame start are ignored
        start(n0);
        frame(8'h00, 48, 1'b0, 1'b0);
        drain("no_vs", n0, 0);

        // continuous frame with hand-checked corner taps
        start(n0);
        frame(8'h00, 48, 1'b0, 1'b1);
        drain("cont", n0, 8);
        check("first_x00", 200'(first_win[0]),  200'(8'h00));
        check("first_x22", 200'(first_win[12]), 200'(8'h22));
        check("first_x44", 200'(first_win[24]), 200'(8'h44));
        check("first_x04", 200'(first_win[4]),  200'(8'h04));
        check("first_x40", 200'(first_win[20]), 200'(8'h40));
        check("last_x44",  200'(last_win[24]),  200'(8'h57));
        check("last_x00",  200'(last_win[0]),   200'(8'h13));

        // beats after frame end (DONE) are ignored
        start(n0);
        for (int i = 0; i < 10; i++) beat(8'(8'hA0 + i));
        drain("done", n0, 0);

        // random gaps between beats
        start(n0);
        frame(8'h00, 48, 1'b1, 1'b1);
        drain("gaps", n0, 8);
        check("gaps_x22", 200'(first_win[12]), 200'(8'h22));

        // frame restarted after four lines, then a full new frame
        start(n0);
        frame(8'h80, 32, 1'b0, 1'b1);
        frame(8'h00, 48, 1'b0, 1'b1);
        drain("restart", n0, 8);

        // reset in the middle of a frame
        frame(8'h00, 30, 1'b0, 1'b1);
        rstn = 1'b0;
        sb.delete();
        m_active = 1'b0;
        @(negedge clk);
        check("midrst_de", 200'(bus.win_de), 200'(0));
        check("midrst_taps", grab_taps(), '0);
        idle(3);
        rstn = 1'b1;
        idle(2);
        start(n0);
        frame(8'h00, 48, 1'b0, 1'b1);
        drain("after_rst", n0, 8);

        // two back-to-back frames with different offsets
        start(n0);
        frame(8'h00, 48, 1'b0, 1'b1);
        frame(8'h80, 48, 1'b0, 1'b1);
        drain("two_frames", n0, 16);
        check("f2_last_x44", 200'(last_win[24]), 200'(8'hD7));
        check("f2_last_x00", 200'(last_win[0]),  200'(8'h93));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/filter_window_5x5.md
# filter_window_5x5

Raster-to-window generator that feeds the 5x5 convolution stage. Accepts one pixel per `i_de` beat in raster order and buffers four previous lines in line memories. On each beat it emits the full 5x5 neighbourhood whose bottom-right pixel is the newest input, in exactly the 25-tap form the convolution stage consumes. Output covers only fully populated windows (no border padding).

## Interface
- `DATA_WIDTH`, 8: pixel width.
- `IMG_WIDTH`, 640: active pixels per line; line-memory depth.
- `IMG_HEIGHT`, 480: active lines per frame.
- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `i_vs` in 1: one-cycle frame-start pulse. Never asserted together with `i_de`.
- `i_de` in 1: pixel valid beat.
- `i_data` in `DATA_WIDTH`: pixel.
- `o_de` out 1: window valid, one-cycle pulse per valid window.
- `o_x00`..`o_x44` out `DATA_WIDTH` each (25 ports): window taps, `o_x<r><c>`.
  - r = 0 is the oldest (top) line; c = 0 is the leftmost column.
  - `o_x44` is the newest pixel.

## Operation
- **FSM** with states IDLE, ACTIVE, DONE; reset enters IDLE.
  - IDLE: `i_de` beats are ignored. `i_vs` moves to ACTIVE and clears `col_cnt` and `row_cnt`.
  - ACTIVE: each beat advances `col_cnt`. At `IMG_WIDTH-1`, `col_cnt` wraps to 0 and `row_cnt` increments. The beat at (`IMG_HEIGHT-1`, `IMG_WIDTH-1`) moves to DONE.
  - DONE: beats are ignored; `o_de` is not generated. `i_vs` returns to ACTIVE with counters cleared.
  - `i_vs` in ACTIVE restarts the frame: counters cleared, stay in ACTIVE. Line-memory contents are not cleared; they are overwritten before they are used.
- **Line memories:** four `filter_line_buf` instances LB0..LB3, each `IMG_WIDTH` x `DATA_WIDTH`, addressed by `col_cnt`.
  - On an accepted beat, each memory does read-before-write at the same address.
  - LB0 writes `i_data`. LBk writes LB(k-1)'s read data for that beat.
  - Read data is valid one cycle after the beat (stage S1).
- **Column vector at S1:** row4 = delayed `i_data`, row3 = LB0, row2 = LB1, row1 = LB2, row0 = LB3.
- **Window shift at S2:** on an S1-valid beat, every row shifts left: `x_r0`<=`x_r1`, ..., `x_r3`<=`x_r4`, then `x_r4`<=the new column entry.
- **Valid rule:** `o_de` pulses for a beat iff that beat was accepted with `row_cnt`>=4 and `col_cnt`>=4. The flag is captured at beat time and pipelined with the data.
- **Window contents:** the window for beat (R,C) holds input pixels (R-4..R, C-4..C). The kernel centre `o_x22` is pixel (R-2, C-2).
- Valid windows per frame = (`IMG_WIDTH`-4)*(`IMG_HEIGHT`-4).
- **`i_de` gaps:** arbitrary; the pipeline advances only on beats and bubbles propagate. Taps hold their value while no beat is present.
- Taps are stale but deterministic when `o_de`=0; downstream qualifies on `o_de` only.

## Timing
- Latency: `o_de` and the taps for a beat are valid exactly 2 `clk` after that beat.
- Throughput: one window per cycle at continuous `i_de`.
- Reset values: `o_de`=0, all `o_x`=0, state IDLE, counters 0, S1/S2 valid flags 0. Memory contents are undefined after reset and are never exposed.
- Reset asserted mid-frame: outputs go to 0 immediately and in-flight beats are discarded. After release, the block waits in IDLE for `i_vs`.
- `i_vs` mid-frame: beats already in S1/S2 still complete, and their `o_de` is still produced.

## Structure
- Shared package `filter_pkg`: `WIN_SIZE`=5, `LB_NUM`=4, FSM state enum (IDLE/ACTIVE/DONE). The convolution stage uses the same `WIN_SIZE`.
- Sub-module `filter_line_buf`: single-clock RAM, one port, synchronous read, read-before-write, `DATA_WIDTH` x `IMG_WIDTH`, with ports `clk`, `i_en`, `i_addr`, `i_wdata`, `o_rdata`.
- Counter widths: `$clog2(IMG_WIDTH)` and `$clog2(IMG_HEIGHT)`.

## Test plan
Parameters `IMG_WIDTH`=8, `IMG_HEIGHT`=6; pixel value = row*16+col.
- **Continuous frame:** `i_vs`, then 48 back-to-back beats.
  - Exactly 8 `o_de` pulses.
  - First pulse arrives 2 cycles after beat (4,4), with `o_x00`=0x00, `o_x22`=0x22, `o_x44`=0x44, `o_x04`=0x04, `o_x40`=0x40.
  - Last pulse: `o_x44`=0x57, `o_x00`=0x13.
- **Random `i_de` gaps** (0-3 idle cycles between beats): same 8 windows with identical values. Each `o_de` arrives 2 cycles after its beat.
- **No `i_vs`:** 48 beats from reset produce no `o_de`. Beats after frame end (DONE) produce no `o_de` until the next `i_vs`.
- **`i_vs` after line 3 of a frame, then a full frame:** exactly 8 pulses, all values matching the new frame's data.
- **`rstn` asserted after 30 beats:** `o_de` and all taps read 0 within the reset. A subsequent `i_vs` plus full frame gives 8 correct windows.
- **Two consecutive frames with different offsets** (second frame adds 0x80): second-frame windows contain no first-frame data.
